// File: rtl/fourier_dft_engine.sv
`default_nettype none
// ============================================================================
// fourier_dft_engine : direct-form N-point complex DFT/IDFT, one complex MAC/cycle
// Revision 1.0
// ============================================================================
module fourier_dft_engine #(
  parameter int N        = 64,
  parameter int W        = 64,
  parameter int AW       = $clog2(N),
  parameter int TW_SCALE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    i_op,
  input  logic [AW-1:0] i_addr,
  input  logic          i_inv,
  input  logic [W-1:0]  i_x_re,
  input  logic [W-1:0]  i_x_im,
  output logic [W-1:0]  o_y_re,
  output logic [W-1:0]  o_y_im,
  output logic          o_busy,
  output logic          o_done
);

  localparam int              c_IW     = $clog2(N);
  localparam logic [c_IW-1:0] c_LAST   = c_IW'(N - 1);
  localparam logic [1:0]      c_OP_WR  = 2'b01;
  localparam logic [1:0]      c_OP_ST  = 2'b10;
  localparam logic [1:0]      c_OP_RD  = 2'b11;
  localparam logic [1:0]      c_IDLE   = 2'd0;
  localparam logic [1:0]      c_MAC    = 2'd1;
  localparam logic [1:0]      c_STORE  = 2'd2;
  localparam logic [1:0]      c_FIN    = 2'd3;
  localparam real             c_PI     = 3.14159265358979323846;

  // Twiddle e^(-2*pi*i*k*j/N) scaled by TW_SCALE, rounded half away from zero.
  function automatic logic [W-1:0] tw_val(input int kk, input int jj, input bit imag);
    real ang;
    real v;
    ang = 2.0 * c_PI * $itor((kk * jj) % N) / $itor(N);
    v   = imag ? -$itor(TW_SCALE) * $sin(ang) : $itor(TW_SCALE) * $cos(ang);
    v   = (v >= 0.0) ? v + 0.5 : v - 0.5;
    return W'($rtoi(v));
  endfunction

  logic [W-1:0] w_tw_re [N][N];
  logic [W-1:0] w_tw_im [N][N];

  for (genvar gk = 0; gk < N; gk++) begin : g_tw_row
    for (genvar gj = 0; gj < N; gj++) begin : g_tw_col
      localparam logic [W-1:0] c_TW_RE = tw_val(gk, gj, 1'b0);
      localparam logic [W-1:0] c_TW_IM = tw_val(gk, gj, 1'b1);
      assign w_tw_re[gk][gj] = c_TW_RE;
      assign w_tw_im[gk][gj] = c_TW_IM;
    end
  end

  logic [1:0]      r_state;
  logic [c_IW-1:0] r_k;
  logic [c_IW-1:0] r_j;
  logic            r_inv;
  logic            r_done;
  logic [W-1:0]    r_acc_re;
  logic [W-1:0]    r_acc_im;
  logic [W-1:0]    r_y_re;
  logic [W-1:0]    r_y_im;
  logic [W-1:0]    r_in_re  [N];
  logic [W-1:0]    r_in_im  [N];
  logic [W-1:0]    r_out_re [N];
  logic [W-1:0]    r_out_im [N];

  logic            w_addr_ok;
  logic [c_IW-1:0] w_idx;
  logic [W-1:0]    w_tr;
  logic [W-1:0]    w_ti;
  logic [W-1:0]    w_xr;
  logic [W-1:0]    w_xi;
  logic [W-1:0]    w_acc_re_nxt;
  logic [W-1:0]    w_acc_im_nxt;

  assign w_addr_ok = ({1'b0, i_addr} < (AW + 1)'(N));
  assign w_idx     = i_addr[c_IW-1:0];

  // Inverse transform conjugates the twiddle; all arithmetic wraps at W bits.
  assign w_tr         = w_tw_re[r_k][r_j];
  assign w_ti         = r_inv ? -w_tw_im[r_k][r_j] : w_tw_im[r_k][r_j];
  assign w_xr         = r_in_re[r_j];
  assign w_xi         = r_in_im[r_j];
  assign w_acc_re_nxt = r_acc_re + w_tr * w_xr - w_ti * w_xi;
  assign w_acc_im_nxt = r_acc_im + w_tr * w_xi + w_ti * w_xr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_IDLE;
      r_k      <= '0;
      r_j      <= '0;
      r_inv    <= 1'b0;
      r_done   <= 1'b0;
      r_acc_re <= '0;
      r_acc_im <= '0;
      r_y_re   <= '0;
      r_y_im   <= '0;
      for (int i = 0; i < N; i++) begin
        r_in_re[i]  <= '0;
        r_in_im[i]  <= '0;
        r_out_re[i] <= '0;
        r_out_im[i] <= '0;
      end
    end else begin
      if (i_op == c_OP_RD) begin
        r_y_re <= w_addr_ok ? r_out_re[w_idx] : '0;
        r_y_im <= w_addr_ok ? r_out_im[w_idx] : '0;
      end
      case (r_state)
        c_IDLE: begin
          if (i_op == c_OP_WR && w_addr_ok) begin
            r_in_re[w_idx] <= i_x_re;
            r_in_im[w_idx] <= i_x_im;
            r_done         <= 1'b0;
          end else if (i_op == c_OP_ST) begin
            r_inv    <= i_inv;
            r_k      <= '0;
            r_j      <= '0;
            r_acc_re <= '0;
            r_acc_im <= '0;
            r_done   <= 1'b0;
            r_state  <= c_MAC;
          end
        end
        c_MAC: begin
          r_acc_re <= w_acc_re_nxt;
          r_acc_im <= w_acc_im_nxt;
          if (r_j == c_LAST) begin
            r_state <= c_STORE;
          end else begin
            r_j <= r_j + c_IW'(1);
          end
        end
        c_STORE: begin
          r_out_re[r_k] <= r_acc_re;
          r_out_im[r_k] <= r_acc_im;
          r_acc_re      <= '0;
          r_acc_im      <= '0;
          r_j           <= '0;
          if (r_k == c_LAST) begin
            r_state <= c_FIN;
          end else begin
            r_k     <= r_k + c_IW'(1);
            r_state <= c_MAC;
          end
        end
        c_FIN: begin
          r_done  <= 1'b1;
          r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign o_y_re = r_y_re;
  assign o_y_im = r_y_im;
  assign o_done = r_done;
  assign o_busy = (r_state == c_MAC) || (r_state == c_STORE);

endmodule
`default_nettype wire

// File: tb/tb_fourier_dft_engine.sv
`default_nettype none
// ============================================================================
// tb_fourier_dft_engine : scoreboard bench for the N=4, W=16 DFT engine
// Revision 1.0
// ============================================================================
module tb_fourier_dft_engine;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    op;
  logic [AW-1:0] addr;
  logic          inv;
  logic [W-1:0]  x_re;
  logic [W-1:0]  x_im;
  logic [W-1:0]  y_re;
  logic [W-1:0]  y_im;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] sh_re [N];
  logic [W-1:0] sh_im [N];
  logic [W-1:0] q_re [$];
  logic [W-1:0] q_im [$];

  always #5 clk = ~clk;

  fourier_dft_engine #(
    .N        (N),
    .W        (W),
    .AW       (AW),
    .TW_SCALE (1)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_op   (op),
    .i_addr (addr),
    .i_inv  (inv),
    .i_x_re (x_re),
    .i_x_im (x_im),
    .o_y_re (y_re),
    .o_y_im (y_im),
    .o_busy (busy),
    .o_done (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_sample(input int a, input logic [W-1:0] re, input logic [W-1:0] im);
    op   = 2'b01;
    addr = AW'(a);
    x_re = re;
    x_im = im;
    tick();
    op   = 2'b00;
    if (a < N) begin
      sh_re[a] = re;
      sh_im[a] = im;
    end
  endtask

  task automatic load(input logic [4*W-1:0] re_pack, input logic [4*W-1:0] im_pack);
    for (int a = 0; a < N; a++) write_sample(a, re_pack[W*a +: W], im_pack[W*a +: W]);
  endtask

  task automatic push_exp(input logic [W-1:0] re, input logic [W-1:0] im);
    q_re.push_back(re);
    q_im.push_back(im);
  endtask

  // Reference DFT with exact twiddles (-j)^(k*j), wrapping at W bits.
  task automatic push_model(input bit inv_v);
    for (int k = 0; k < N; k++) begin
      logic [W-1:0] ar;
      logic [W-1:0] ai;
      ar = '0;
      ai = '0;
      for (int j = 0; j < N; j++) begin
        logic [W-1:0] tr;
        logic [W-1:0] ti;
        case ((k * j) % N)
          0:       begin tr = 16'd1;    ti = 16'd0;    end
          1:       begin tr = 16'd0;    ti = 16'hFFFF; end
          2:       begin tr = 16'hFFFF; ti = 16'd0;    end
          default: begin tr = 16'd0;    ti = 16'd1;    end
        endcase
        if (inv_v) ti = -ti;
        ar = ar + tr * sh_re[j] - ti * sh_im[j];
        ai = ai + tr * sh_im[j] + ti * sh_re[j];
      end
      push_exp(ar, ai);
    end
  endtask

  task automatic push_fwd_1234();
    push_exp(16'd10, 16'd0);
    push_exp(16'hFFFE, 16'd2);
    push_exp(16'hFFFE, 16'd0);
    push_exp(16'hFFFE, 16'hFFFE);
  endtask

  task automatic run_transform(input bit inv_v, input bit perturb, input string tag);
    bit busy_bad;
    int lat;
    busy_bad = 1'b0;
    lat      = -1;
    op  = 2'b10;
    inv = inv_v;
    tick();
    op  = 2'b00;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s start: busy=%b done=%b, required busy=1 done=0", tag, busy, done);
    end
    for (int n = 1; n <= 100; n++) begin
      if (perturb && n == 7) begin
        op = 2'b01; addr = '0; x_re = 16'd99; x_im = 16'd5;
      end else if (perturb && n == 8) begin
        op = 2'b10; inv = ~inv_v;
      end else begin
        op = 2'b00;
      end
      tick();
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      if (n < 20 && busy !== 1'b1) busy_bad = 1'b1;
    end
    op = 2'b00;
    n_checks++;
    if (lat != 21) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles, required 21", tag, lat);
    end
    n_checks++;
    if (busy_bad || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy window: dropped_early=%b busy_at_done=%b, required 0 and 0", tag, busy_bad, busy);
    end
  endtask

  task automatic drain(input string tag);
    for (int a = 0; a < N; a++) begin
      logic [W-1:0] er;
      logic [W-1:0] ei;
      op   = 2'b11;
      addr = AW'(a);
      tick();
      op   = 2'b00;
      n_checks++;
      if (q_re.size() == 0) begin
        n_fail++;
        $display("FAIL %s scoreboard empty at addr %0d", tag, a);
      end else begin
        er = q_re.pop_front();
        ei = q_im.pop_front();
        if (y_re !== er || y_im !== ei) begin
          n_fail++;
          $display("FAIL %s out[%0d]: got re=%h im=%h, required re=%h im=%h", tag, a, y_re, y_im, er, ei);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({y_re, y_im, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: got y_re=%h y_im=%h busy=%b done=%b, required all 0", y_re, y_im, busy, done);
    end
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < N; a++) begin
      sh_re[a] = '0;
      sh_im[a] = '0;
      push_exp('0, '0);
    end
    drain("reset buffers");
  endtask

  task automatic test_forward();
    load({16'd4, 16'd3, 16'd2, 16'd1}, '0);
    push_fwd_1234();
    run_transform(1'b0, 1'b0, "forward");
    drain("forward");
  endtask

  task automatic test_inverse();
    load({16'hFFFE, 16'hFFFE, 16'hFFFE, 16'd10}, {16'hFFFE, 16'd0, 16'd2, 16'd0});
    push_exp(16'd4, 16'd0);
    push_exp(16'd8, 16'd0);
    push_exp(16'd12, 16'd0);
    push_exp(16'd16, 16'd0);
    run_transform(1'b1, 1'b0, "inverse");
    drain("inverse");
  endtask

  task automatic test_wrap();
    load({16'd20000, 16'd20000, 16'd20000, 16'd20000}, '0);
    push_exp(16'd14464, 16'd0);
    for (int k = 1; k < N; k++) push_exp('0, '0);
    run_transform(1'b0, 1'b0, "wrap");
    drain("wrap");
  endtask

  task automatic test_busy_ignore();
    load({16'd4, 16'd3, 16'd2, 16'd1}, '0);
    push_fwd_1234();
    run_transform(1'b0, 1'b1, "busy ignore");
    drain("busy ignore");
  endtask

  task automatic test_bounds();
    op   = 2'b11;
    addr = 3'd4;
    tick();
    op   = 2'b00;
    n_checks++;
    if (y_re !== '0 || y_im !== '0) begin
      n_fail++;
      $display("FAIL read addr 4: got re=%h im=%h, required 0 0", y_re, y_im);
    end
    write_sample(5, 16'd77, 16'd88);
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL done after bad-addr write: got %b, required 1", done);
    end
    push_fwd_1234();
    run_transform(1'b0, 1'b0, "after bad write");
    drain("after bad write");
    write_sample(0, 16'd1, 16'd0);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done after valid write: got %b, required 0", done);
    end
  endtask

  task automatic test_back_to_back();
    push_fwd_1234();
    run_transform(1'b0, 1'b0, "b2b first");
    drain("b2b first");
    push_fwd_1234();
    run_transform(1'b0, 1'b0, "b2b repeat");
    drain("b2b repeat");
    for (int it = 0; it < 2; it++) begin
      for (int a = 0; a < N; a++) write_sample(a, W'($urandom), W'($urandom));
      push_model(it[0]);
      run_transform(it[0], 1'b0, "random");
      drain("random");
    end
    load({16'd4, 16'd3, 16'd2, 16'd1}, '0);
  endtask

  task automatic test_reset_mid();
    op  = 2'b10;
    inv = 1'b0;
    tick();
    op  = 2'b00;
    for (int n = 1; n < 10; n++) tick();
    op   = 2'b11;
    addr = '0;
    tick();
    op   = 2'b00;
    n_checks++;
    if (y_re !== 16'd10 || y_im !== 16'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL read while busy: got re=%h im=%h busy=%b, required 000a 0000 1", y_re, y_im, busy);
    end
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({y_re, y_im, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL async reset: got y_re=%h y_im=%h busy=%b done=%b, required all 0", y_re, y_im, busy, done);
    end
    tick();
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < N; a++) begin
      sh_re[a] = '0;
      sh_im[a] = '0;
      push_exp('0, '0);
    end
    drain("post-reset read");
    push_model(1'b0);
    run_transform(1'b0, 1'b0, "post-reset run");
    drain("post-reset run");
  endtask

  initial begin
    rst_n = 1'b0;
    op    = 2'b00;
    addr  = '0;
    inv   = 1'b0;
    x_re  = '0;
    x_im  = '0;
    test_reset();
    test_forward();
    test_inverse();
    test_wrap();
    test_busy_ignore();
    test_bounds();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
